// File: rtl/alu_mc_controller.sv
// rtl/alu_mc_controller.sv - multicycle MIPS-style ALU/datapath control FSM
// Optional JAL state enabled by defining ALU_MC_JAL_EN.
module alu_mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [5:0] alu_f,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       pcwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       iord,
  output logic       zeroext,
  output logic [1:0] pcsrc,
  output logic [1:0] regdst,
  output logic [1:0] wdsel,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMRD    = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWR    = 4'd5;
  localparam logic [3:0] S_RTYPE_EX = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_IMM_EX   = 4'd9;
  localparam logic [3:0] S_IMMWB    = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
`ifdef ALU_MC_JAL_EN
  localparam logic [3:0] S_JAL      = 4'd12;
`endif

  logic [3:0] state_q, state_d;
  logic [5:0] r_f, i_f;
  logic       r_ok;

  // R-type funct and I-type opcode to ALU function maps
  always_comb begin
    r_ok = 1'b1;
    r_f  = 6'd0;
    case (funct)
      6'h20, 6'h21: r_f = 6'd0;
      6'h22, 6'h23: r_f = 6'd1;
      6'h24:        r_f = 6'd2;
      6'h25:        r_f = 6'd3;
      6'h26:        r_f = 6'd4;
      6'h27:        r_f = 6'd10;
      6'h2A:        r_f = 6'd8;
      6'h2B:        r_f = 6'd9;
      6'h00:        r_f = 6'd5;
      6'h02:        r_f = 6'd6;
      6'h03:        r_f = 6'd7;
      6'h04:        r_f = 6'd11;
      6'h06:        r_f = 6'd12;
      6'h07:        r_f = 6'd13;
      6'h08:        r_f = 6'd15;
      default:      r_ok = 1'b0;
    endcase
    i_f = 6'd0;
    case (op)
      6'h0A:   i_f = 6'd8;
      6'h0B:   i_f = 6'd9;
      6'h0C:   i_f = 6'd2;
      6'h0D:   i_f = 6'd3;
      6'h0E:   i_f = 6'd4;
      6'h0F:   i_f = 6'd14;
      default: i_f = 6'd0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    alu_f    = 6'd0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcwrite  = 1'b0;
    irwrite  = 1'b0;
    regwrite = 1'b0;
    memwrite = 1'b0;
    iord     = 1'b0;
    zeroext  = 1'b0;
    pcsrc    = 2'b00;
    regdst   = 2'b00;
    wdsel    = 2'b00;
    illegal  = 1'b0;
    case (state_q)
      S_FETCH: begin
        irwrite = 1'b1;
        alusrcb = 2'b01;
        pcwrite = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          6'h00:        state_d = S_RTYPE_EX;
          6'h23, 6'h2B: state_d = S_MEMADR;
          6'h04, 6'h05: state_d = S_BRANCH;
          6'h08, 6'h09, 6'h0A, 6'h0B,
          6'h0C, 6'h0D, 6'h0E, 6'h0F: state_d = S_IMM_EX;
          6'h02:        state_d = S_JUMP;
`ifdef ALU_MC_JAL_EN
          6'h03:        state_d = S_JAL;
`endif
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        if (op == 6'h2B)      state_d = S_MEMWR;
        else if (op == 6'h23) state_d = S_MEMRD;
        else                  state_d = S_FETCH;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        wdsel    = 2'b01;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_RTYPE_EX: begin
        alusrca = 1'b1;
        if (!r_ok) begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end else begin
          alu_f = r_f;
          // jr retires here: the PC is written straight from the ALU result
          if (funct == 6'h08) begin
            pcwrite = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_ALUWB;
          end
        end
      end
      S_ALUWB: begin
        regdst   = 2'b01;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        alu_f   = 6'd1;
        pcsrc   = 2'b01;
        pcwrite = (op == 6'h04) ? zero : ((op == 6'h05) ? ~zero : 1'b0);
        state_d = S_FETCH;
      end
      S_IMM_EX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        alu_f   = i_f;
        zeroext = (op == 6'h0C) || (op == 6'h0D) || (op == 6'h0E);
        state_d = S_IMMWB;
      end
      S_IMMWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        state_d = S_FETCH;
      end
`ifdef ALU_MC_JAL_EN
      S_JAL: begin
        pcsrc    = 2'b10;
        pcwrite  = 1'b1;
        regdst   = 2'b10;
        wdsel    = 2'b10;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
`endif
      default: state_d = S_FETCH;
    endcase
    // Reset parks the datapath controls on their FETCH values with all writes off
    if (reset) begin
      state_d  = S_FETCH;
      alu_f    = 6'd0;
      alusrca  = 1'b0;
      alusrcb  = 2'b01;
      pcwrite  = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      memwrite = 1'b0;
      iord     = 1'b0;
      zeroext  = 1'b0;
      pcsrc    = 2'b00;
      regdst   = 2'b00;
      wdsel    = 2'b00;
      illegal  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  assign state = state_q;

endmodule
